alu_result_stage: RTL and testbench

Registered output stage placed directly downstream of the ALU comparison and arithmetic parts. It selects between the comparison result and the general ALU result, tags the result with its destination register, and buffers it in a 2-entry skid buffer with a valid/ready handshake toward register writeback. The ALU therefore never stalls combinationally on writeback backpressure. A free-running retire counter supports debug and performance inspection.

---
 rtl/alu_result_stage.sv | 202 ++++++++++++++++++++
 tb/tb_alu_result_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// ALU result output stage: result select, destination tagging and a 2-entry skid buffer toward writeback.
// Optional macro ALU_RESULT_STAGE_FLAGS_EN stores zero/negative flags with each entry.
module alu_result_stage #(
    parameter int W  = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  alu_result,
    input  logic [W-1:0]  cmp_result,
    input  logic          sel_cmp,
    input  logic [RW-1:0] rd_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [RW-1:0] out_rd,
    output logic          out_zero,
    output logic          out_neg,
    output logic [CW-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  sel_data_s;
    logic [W-1:0]  main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [RW-1:0] main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_xfer_s, out_xfer_s;
    logic          load_main_s, load_skid_s, shift_s;
    logic          unused_cmp_s;

    // Only bit 0 of the comparison result carries information.
    assign unused_cmp_s = ^cmp_result[W-1:1];

    // Result selection between comparison and arithmetic paths
    always_comb begin
        sel_data_s = alu_result;
        if (sel_cmp) begin
            sel_data_s = {{(W-1){1'b0}}, cmp_result[0]};
        end else begin
            sel_data_s = alu_result;
        end
    end

    assign in_ready   = (state_q != ST_FULL);
    assign out_valid  = (state_q != ST_EMPTY);
    assign in_xfer_s  = in_valid && in_ready;
    assign out_xfer_s = out_valid && out_ready;

    // Occupancy FSM next state and entry load controls
    always_comb begin
        state_d     = state_q;
        load_main_s = 1'b0;
        load_skid_s = 1'b0;
        shift_s     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer_s) begin
                    load_main_s = 1'b1;
                    state_d     = ST_ONE;
                end else begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_xfer_s && out_xfer_s) begin
                    load_main_s = 1'b1;
                    state_d     = ST_ONE;
                end else if (in_xfer_s) begin
                    load_skid_s = 1'b1;
                    state_d     = ST_FULL;
                end else if (out_xfer_s) begin
                    state_d     = ST_EMPTY;
                end else begin
                    state_d     = ST_ONE;
                end
            end
            ST_FULL: begin
                if (out_xfer_s) begin
                    shift_s = 1'b1;
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Entry datapath next values
    always_comb begin
        main_data_d = main_data_q;
        main_rd_d   = main_rd_q;
        skid_data_d = skid_data_q;
        skid_rd_d   = skid_rd_q;
        if (load_main_s) begin
            main_data_d = sel_data_s;
            main_rd_d   = rd_addr;
        end else if (shift_s) begin
            main_data_d = skid_data_q;
            main_rd_d   = skid_rd_q;
        end else begin
            main_data_d = main_data_q;
            main_rd_d   = main_rd_q;
        end
        if (load_skid_s) begin
            skid_data_d = sel_data_s;
            skid_rd_d   = rd_addr;
        end else begin
            skid_data_d = skid_data_q;
            skid_rd_d   = skid_rd_q;
        end
    end

    // Retire counter next value, wrapping naturally
    always_comb begin
        cnt_d = cnt_q;
        if (out_xfer_s) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, entry and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_rd_q   <= '0;
            skid_data_q <= '0;
            skid_rd_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_rd_q   <= main_rd_d;
            skid_data_q <= skid_data_d;
            skid_rd_q   <= skid_rd_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_data   = main_data_q;
    assign out_rd     = main_rd_q;
    assign retire_cnt = cnt_q;

`ifdef ALU_RESULT_STAGE_FLAGS_EN
    // {negative, zero} flags of a selected result
    function automatic logic [1:0] flags_of(input logic [W-1:0] d);
        return {d[W-1], (d == {W{1'b0}})};
    endfunction

    logic [1:0] main_flags_q, main_flags_d, skid_flags_q, skid_flags_d;

    // Flag next values follow the same moves as the data
    always_comb begin
        main_flags_d = main_flags_q;
        skid_flags_d = skid_flags_q;
        if (load_main_s) begin
            main_flags_d = flags_of(sel_data_s);
        end else if (shift_s) begin
            main_flags_d = skid_flags_q;
        end else begin
            main_flags_d = main_flags_q;
        end
        if (load_skid_s) begin
            skid_flags_d = flags_of(sel_data_s);
        end else begin
            skid_flags_d = skid_flags_q;
        end
    end

    // Flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_flags_q <= 2'b00;
            skid_flags_q <= 2'b00;
        end else begin
            main_flags_q <= main_flags_d;
            skid_flags_q <= skid_flags_d;
        end
    end

    assign out_neg  = main_flags_q[1];
    assign out_zero = main_flags_q[0];
`else
    assign out_neg  = 1'b0;
    assign out_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage, built with a 4-bit retire counter to exercise wrap.
module tb_alu_result_stage;

    localparam int W  = 32;
    localparam int RW = 5;
    localparam int CW = 4;

`ifdef ALU_RESULT_STAGE_FLAGS_EN
    localparam logic [31:0] FLAG_ON = 32'd1;
`else
    localparam logic [31:0] FLAG_ON = 32'd0;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  alu_result;
    logic [W-1:0]  cmp_result;
    logic          sel_cmp;
    logic [RW-1:0] rd_addr;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [RW-1:0] out_rd;
    logic          out_zero;
    logic          out_neg;
    logic [CW-1:0] retire_cnt;

    int total;
    int bad;

    alu_result_stage #(.W(W), .RW(RW), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .cmp_result (cmp_result),
        .sel_cmp    (sel_cmp),
        .rd_addr    (rd_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [RW-1:0] rd);
        in_valid   = 1'b1;
        sel_cmp    = 1'b0;
        alu_result = d;
        rd_addr    = rd;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        alu_result = 32'd0;
        cmp_result = 32'd0;
        sel_cmp    = 1'b0;
        rd_addr    = 5'd0;
        out_ready  = 1'b0;
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_zero", {31'd0, out_zero}, 32'd0);
        chk("rst_neg", {31'd0, out_neg}, 32'd0);
        chk("rst_cnt", {28'd0, retire_cnt}, 32'd0);
        #9;
        rst_n = 1'b1;
        step();

        // single transfer
        push(32'h0000_0005, 5'd3);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_data", out_data, 32'd5);
        chk("single_rd", {27'd0, out_rd}, 32'd3);
        chk("single_cnt_before", {28'd0, retire_cnt}, 32'd0);
        step();
        chk("single_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("single_cnt", {28'd0, retire_cnt}, 32'd1);

        // comparison select, then simultaneous in/out in ONE
        in_valid   = 1'b1;
        sel_cmp    = 1'b1;
        cmp_result = 32'hFFFF_FFFF;
        alu_result = 32'h1234_5678;
        rd_addr    = 5'd7;
        step();
        chk("cmp_one_data", out_data, 32'd1);
        chk("cmp_one_zero", {31'd0, out_zero}, 32'd0);
        cmp_result = 32'hFFFF_FFFE;
        rd_addr    = 5'd8;
        step();
        in_valid = 1'b0;
        sel_cmp  = 1'b0;
        chk("cmp_zero_data", out_data, 32'd0);
        chk("cmp_zero_rd", {27'd0, out_rd}, 32'd8);
        chk("cmp_zero_flag", {31'd0, out_zero}, FLAG_ON);
        chk("cmp_cnt", {28'd0, retire_cnt}, 32'd2);
        step();
        chk("cmp_cnt2", {28'd0, retire_cnt}, 32'd3);

        // backpressure: fill with 10, 20, then offer 30 while full
        out_ready = 1'b0;
        push(32'd10, 5'd1);
        step();
        chk("bp_ready_one", {31'd0, in_ready}, 32'd1);
        push(32'd20, 5'd2);
        step();
        chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
        chk("bp_head", out_data, 32'd10);
        push(32'd30, 5'd3);
        step();
        step();
        chk("bp_hold_data", out_data, 32'd10);
        chk("bp_hold_rd", {27'd0, out_rd}, 32'd1);
        chk("bp_hold_cnt", {28'd0, retire_cnt}, 32'd3);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_second", out_data, 32'd20);
        chk("bp_second_rd", {27'd0, out_rd}, 32'd2);
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);
        push(32'd30, 5'd3);
        step();
        in_valid = 1'b0;
        chk("bp_third", out_data, 32'd30);
        step();
        chk("bp_cnt", {28'd0, retire_cnt}, 32'd6);

        // streaming 1..8 with no bubbles
        for (int i = 1; i <= 8; i++) begin
            push(i, i[4:0]);
            step();
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_data", out_data, i);
            chk("stream_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_done", {31'd0, out_valid}, 32'd0);
        chk("stream_cnt", {28'd0, retire_cnt}, 32'd14);

        // asynchronous reset while FULL
        out_ready = 1'b0;
        push(32'd40, 5'd4);
        step();
        push(32'd50, 5'd5);
        step();
        in_valid = 1'b0;
        chk("rf_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rf_valid", {31'd0, out_valid}, 32'd0);
        chk("rf_ready", {31'd0, in_ready}, 32'd1);
        chk("rf_data", out_data, 32'd0);
        chk("rf_cnt", {28'd0, retire_cnt}, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        chk("rf_after", {31'd0, out_valid}, 32'd0);

        // 17 transfers across the counter wrap, last one negative
        out_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            push((i == 16) ? 32'h8000_0000 : 32'd100 + i, 5'd9);
            step();
            chk("wrap_data", out_data, (i == 16) ? 32'h8000_0000 : 32'd100 + i);
            chk("wrap_cnt_run", {28'd0, retire_cnt}, i % 16);
        end
        in_valid = 1'b0;
        chk("wrap_neg", {31'd0, out_neg}, FLAG_ON);
        chk("wrap_zero", {31'd0, out_zero}, 32'd0);
        step();
        chk("wrap_cnt", {28'd0, retire_cnt}, 32'd1);
        chk("wrap_empty", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
